mean_window_ctrl: RTL and testbench
===================================

Name: mean_window_ctrl

Overview:
- Initiator-side sequencer for the EEG mean-accumulator/divider block.
- Accepts an upstream EEG sample stream on a valid/ready handshake and forwards each sample to the accumulator with a one-cycle strobe.
- After WIN_LEN samples it issues the divide-start pulse and waits for divider completion, with a timeout.
- Latches the mean and presents it downstream on a valid/ready handshake. Sits between the sample buffer and the feature-extraction stage.

Parameters:
- WIN_LEN, 256, samples per window; range 2..256.
- DATA_W, 18, sample/mean width, Q1.5.12.
- TIMEOUT, 15, maximum cycles from start_div to completion edge before error.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream sample valid
- s_ready  out  1  upstream ready
- s_data  in  DATA_W  EEG sample, Q1.5.12
- acc_start  out  1  accumulate strobe to mean block
- acc_eeg  out  DATA_W  sample to mean block, valid with acc_start
- start_div  out  1  divide-start pulse to mean block
- complete_div  in  1  divider completion level from mean block
- mean_in  in  DATA_W  mean from mean block
- acc_count  in  8  mean block's running count
- m_valid  out  1  mean output valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  latched mean
- busy  out  1  high in any state other than COLLECT
- err_timeout  out  1  sticky divider-timeout flag

Behaviour:
Reset:
- Asynchronous, active-low.
- All outputs 0; state COLLECT; win_cnt 0; to counter 0.
- Reset mid-operation aborts the window; no pulse is emitted after reset deasserts until new samples arrive.

FSM states: COLLECT, DRAIN, DIV_START, DIV_WAIT, OUT.

COLLECT:
- s_ready = 1.
- Handshake occurs when s_valid & s_ready. Each handshake:
  - next cycle acc_start = 1 and acc_eeg = s_data (registered, 1-cycle latency);
  - win_cnt increments.
- Handshake at win_cnt == WIN_LEN-1: win_cnt clears to 0; go to DRAIN.
- No handshake: acc_start = 0; acc_eeg holds its last value.

DRAIN:
- s_ready = 0; one cycle, so the final acc_start lands in the accumulator.
- Go to DIV_START.

DIV_START:
- start_div = 1 for exactly one cycle; timeout counter loads 0.
- Go to DIV_WAIT.

DIV_WAIT:
- s_ready = 0; timeout counter increments each cycle.
- Completion is a rising edge of complete_div (registered previous value 0, current value 1). A level that is already high is ignored.
- On completion: m_data <= mean_in; m_valid <= 1; go to OUT.
- Counter reaching TIMEOUT without an edge: err_timeout <= 1 (sticky until reset); m_valid stays 0; return to COLLECT.
- Completion edge and timeout in the same cycle: completion wins.

OUT:
- m_valid = 1 and m_data stable until m_ready.
- On m_valid & m_ready: m_valid <= 0 next cycle; go to COLLECT.
- s_ready = 0 throughout (backpressure holds upstream).

Latency:
- Last sample handshake at cycle T: acc_start at T+1, start_div at T+2.
- With a 3-cycle divider, m_valid is asserted by T+10.

Other rules:
- busy = (state != COLLECT).
- start_div and acc_start are never high in the same cycle.

Optional Feature:
MEAN_WIN_CNT_CHK_EN
- Defined:
  - adds output err_count (1 bit, sticky, reset 0);
  - in DIV_START, err_count <= 1 if acc_count != (total handshaken samples since reset) mod 256;
  - flow is otherwise unchanged.
- Undefined: port absent; acc_count unused.

Test Plan:
1. Stream 256 samples of 0x01000 (1.0), s_valid held high, m_ready high -> 256 acc_start pulses, one start_div 1 cycle after the final acc_start, m_valid within 8 cycles of start_div, m_data equals mean_in captured at the complete_div rising edge.
2. Random s_valid gaps (50% duty) over one window -> exactly 256 acc_start pulses, acc_eeg order matches input, s_ready = 0 from DRAIN through OUT.
3. m_ready held low 20 cycles in OUT -> m_valid and m_data stable for 20 cycles, s_ready = 0; release -> m_valid drops next cycle, s_ready = 1.
4. complete_div held high (never toggles) after start_div -> err_timeout = 1 after 15 cycles, m_valid never asserted, FSM back in COLLECT accepting samples.
5. reset_n asserted in DIV_WAIT -> all outputs 0 immediately; next window of 256 samples completes normally.
6. With MEAN_WIN_CNT_CHK_EN, acc_count forced to 5 at start_div -> err_count = 1; with matching acc_count -> err_count stays 0.

Source files
------------

// File: rtl/mean_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mean_window_ctrl                                                |
// | Purpose  : Windowed sample sequencer for the EEG mean accumulator/divider. |
// |            Optional acc_count cross-check: define MEAN_WIN_CNT_CHK_EN.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mean_window_ctrl #(
    parameter int WIN_LEN = 256,
    parameter int DATA_W  = 18,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              acc_start,
    output logic [DATA_W-1:0] acc_eeg,
    output logic              start_div,
    input  logic              complete_div,
    input  logic [DATA_W-1:0] mean_in,
    input  logic [7:0]        acc_count,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
`ifdef MEAN_WIN_CNT_CHK_EN
    output logic              err_count,
`endif
    output logic              err_timeout
);

    localparam logic [2:0] c_COLLECT   = 3'd0;
    localparam logic [2:0] c_DRAIN     = 3'd1;
    localparam logic [2:0] c_DIV_START = 3'd2;
    localparam logic [2:0] c_DIV_WAIT  = 3'd3;
    localparam logic [2:0] c_OUT       = 3'd4;

    localparam int               c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);
    localparam logic [7:0]        c_WIN_LAST = 8'(WIN_LEN - 1);

    logic [2:0]        r_state;
    logic [7:0]        r_win_cnt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_cdiv_q;
    logic              r_s_ready;
    logic              r_acc_start;
    logic [DATA_W-1:0] r_acc_eeg;
    logic              r_start_div;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_err_timeout;

    logic w_hs;
    logic w_cdiv_rise;

    // r_s_ready is only ever set while in COLLECT, so it alone qualifies the handshake
    assign w_hs        = s_valid & r_s_ready;
    assign w_cdiv_rise = complete_div & ~r_cdiv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_COLLECT;
            r_win_cnt     <= 8'd0;
            r_to_cnt      <= '0;
            r_cdiv_q      <= 1'b0;
            r_s_ready     <= 1'b0;
            r_acc_start   <= 1'b0;
            r_acc_eeg     <= '0;
            r_start_div   <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_cdiv_q    <= complete_div;
            r_acc_start <= 1'b0;
            r_start_div <= 1'b0;
            case (r_state)
                c_COLLECT: begin
                    r_s_ready <= 1'b1;
                    if (w_hs) begin
                        r_acc_start <= 1'b1;
                        r_acc_eeg   <= s_data;
                        if (r_win_cnt == c_WIN_LAST) begin
                            r_win_cnt <= 8'd0;
                            r_s_ready <= 1'b0;
                            r_state   <= c_DRAIN;
                        end else begin
                            r_win_cnt <= r_win_cnt + 8'd1;
                        end
                    end
                end
                // one idle cycle lets the final accumulate land before the divide
                c_DRAIN: begin
                    r_start_div <= 1'b1;
                    r_state     <= c_DIV_START;
                end
                c_DIV_START: begin
                    r_to_cnt <= '0;
                    r_state  <= c_DIV_WAIT;
                end
                c_DIV_WAIT: begin
                    r_to_cnt <= r_to_cnt + c_TO_ONE;
                    if (w_cdiv_rise) begin
                        r_m_data  <= mean_in;
                        r_m_valid <= 1'b1;
                        r_state   <= c_OUT;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_s_ready     <= 1'b1;
                        r_state       <= c_COLLECT;
                    end
                end
                c_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= c_COLLECT;
                    end
                end
                default: begin
                    r_s_ready <= 1'b0;
                    r_state   <= c_COLLECT;
                end
            endcase
        end
    end

`ifdef MEAN_WIN_CNT_CHK_EN
    logic [7:0] r_hs_total;
    logic       r_err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_total  <= 8'd0;
            r_err_count <= 1'b0;
        end else begin
            if (w_hs) begin
                r_hs_total <= r_hs_total + 8'd1;
            end
            if ((r_state == c_DIV_START) && (acc_count != r_hs_total)) begin
                r_err_count <= 1'b1;
            end
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_acc_count;
    assign w_unused_acc_count = ^acc_count;
`endif

    assign s_ready     = r_s_ready;
    assign acc_start   = r_acc_start;
    assign acc_eeg     = r_acc_eeg;
    assign start_div   = r_start_div;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign busy        = (r_state != c_COLLECT);
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mean_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mean_window_ctrl                                             |
// | Purpose  : Self-checking bench for mean_window_ctrl with a mean-block model.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mean_window_ctrl;

    localparam int WIN_LEN = 256;
    localparam int DATA_W  = 18;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              acc_start;
    logic [DATA_W-1:0] acc_eeg;
    logic              start_div;
    logic              complete_div;
    logic [DATA_W-1:0] mean_in;
    logic [7:0]        acc_count;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              busy;
    logic              err_timeout;
`ifdef MEAN_WIN_CNT_CHK_EN
    logic              err_count;
`endif

    always #5 clk = ~clk;

    mean_window_ctrl #(
        .WIN_LEN(WIN_LEN),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .acc_start   (acc_start),
        .acc_eeg     (acc_eeg),
        .start_div   (start_div),
        .complete_div(complete_div),
        .mean_in     (mean_in),
        .acc_count   (acc_count),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
`ifdef MEAN_WIN_CNT_CHK_EN
        .err_count   (err_count),
`endif
        .err_timeout (err_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // expected outputs
    bit                e_s_ready, e_acc_start, e_start_div, e_m_valid, e_busy, e_err_to, e_err_cnt;
    logic [DATA_W-1:0] e_acc_eeg, e_m_data;
    int                e_win, e_total, e_n;
    bit                fresh;

    // mean-block environment
    bit                prev_cdiv, hold_high, force_cnt;
    int                since_sd, div_lat, out_hold, out_wait;
    longint            sum;
    logic [DATA_W-1:0] win_mean;

    // observed statistics
    int acc_pulses, sd_pulses, mv_cycles, sd_cyc, mv_cyc, to_cyc;
    bit prev_mv_act, prev_to_act;

    typedef struct {
        bit                sv;
        logic [DATA_W-1:0] sd;
        bit                rdy;
        bit                as;
        logic [DATA_W-1:0] eeg;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        e_s_ready = 0; e_acc_start = 0; e_start_div = 0; e_m_valid = 0; e_busy = 0;
        e_err_to = 0; e_err_cnt = 0; e_acc_eeg = '0; e_m_data = '0;
        e_win = 0; e_total = 0; e_n = -1; fresh = 1;
        prev_cdiv = 0; hold_high = 0; force_cnt = 0; since_sd = -1; div_lat = 3;
        out_hold = 0; out_wait = 0; sum = 0; win_mean = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"},     32'(s_ready),     32'd0);
        chk({tag, "_acc_start"},   32'(acc_start),   32'd0);
        chk({tag, "_acc_eeg"},     32'(acc_eeg),     32'd0);
        chk({tag, "_start_div"},   32'(start_div),   32'd0);
        chk({tag, "_m_valid"},     32'(m_valid),     32'd0);
        chk({tag, "_m_data"},      32'(m_data),      32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
`ifdef MEAN_WIN_CNT_CHK_EN
        chk({tag, "_err_count"},   32'(err_count),   32'd0);
`endif
    endtask

    // One clock: drive the mean-block model, advance, predict, compare.
    task automatic step();
        bit hs, rise, cd_now;
        cd_now       = hold_high || (since_sd >= div_lat);
        rise         = cd_now && !prev_cdiv;
        complete_div = cd_now;
        mean_in      = rise ? win_mean : DATA_W'($urandom);
        acc_count    = force_cnt ? 8'd5 : 8'(e_total);
        m_ready      = (out_hold == 0) || (out_wait > out_hold);
        @(posedge clk);
        hs          = s_valid && e_s_ready;
        prev_cdiv   = cd_now;
        e_acc_start = hs;
        if (hs) e_acc_eeg = s_data;
        e_start_div = 0;
        if (fresh) begin
            e_s_ready = 1;
            fresh     = 0;
        end
        if (e_m_valid && m_ready) begin
            e_m_valid = 0; e_s_ready = 1; e_busy = 0;
        end
        // e_n: clock edges since the handshake that closed the window
        if (e_n >= 0) begin
            e_n++;
            if (e_n == 1) begin
                e_start_div = 1;
            end else if (e_n == 2) begin
                if (acc_count != 8'(e_total)) e_err_cnt = 1;
            end else if (rise) begin
                e_m_valid = 1; e_m_data = mean_in; e_n = -1;
            end else if (e_n == TIMEOUT + 2) begin
                e_err_to = 1; e_s_ready = 1; e_busy = 0; e_n = -1;
            end
        end
        if (hs) begin
            e_total++;
            sum += longint'($signed(s_data));
            e_win++;
            if (e_win == WIN_LEN) begin
                e_win = 0; e_s_ready = 0; e_busy = 1; e_n = 0;
            end
        end
        if (e_start_div) begin
            since_sd = 0;
            win_mean = DATA_W'(sum / WIN_LEN);
            sum      = 0;
        end else if (since_sd >= 0) begin
            since_sd++;
        end
        out_wait = e_m_valid ? out_wait + 1 : 0;
        #1;
        cyc++;
        chk("s_ready",     32'(s_ready),     32'(e_s_ready));
        chk("acc_start",   32'(acc_start),   32'(e_acc_start));
        chk("acc_eeg",     32'(acc_eeg),     32'(e_acc_eeg));
        chk("start_div",   32'(start_div),   32'(e_start_div));
        chk("m_valid",     32'(m_valid),     32'(e_m_valid));
        chk("m_data",      32'(m_data),      32'(e_m_data));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("err_timeout", 32'(err_timeout), 32'(e_err_to));
`ifdef MEAN_WIN_CNT_CHK_EN
        chk("err_count",   32'(err_count),   32'(e_err_cnt));
`endif
        if (acc_start) acc_pulses++;
        if (start_div) begin
            sd_pulses++;
            sd_cyc = cyc;
        end
        if (m_valid) mv_cycles++;
        if (m_valid && !prev_mv_act) mv_cyc = cyc;
        if (err_timeout && !prev_to_act) to_cyc = cyc;
        prev_mv_act = m_valid;
        prev_to_act = err_timeout;
    endtask

    task automatic run_window(input bit cnst, input bit gaps, input int lat, input bit hold,
                              input int ohold, input bit force_c);
        int target, guard;
        div_lat = lat; hold_high = hold; out_hold = ohold; force_cnt = force_c;
        acc_pulses = 0; sd_pulses = 0; mv_cycles = 0; out_wait = 0;
        sd_cyc = -1; mv_cyc = -1; to_cyc = -1;
        target = e_total + WIN_LEN;
        guard  = 0;
        while ((e_total < target || e_n >= 0 || e_m_valid) && guard < 3000) begin
            if (e_total < target) s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            else                  s_valid = 1'($urandom_range(0, 1));
            s_data = cnst ? 18'h01000 : DATA_W'($urandom);
            step();
            guard++;
        end
        chk("window_budget", 32'(guard < 3000), 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        complete_div = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 18'h00AAA, 1'b1, 1'b0, 18'h00000};
        tbl[1] = '{1'b1, 18'h2F00B, 1'b1, 1'b1, 18'h2F00B};
        tbl[2] = '{1'b0, 18'h11111, 1'b1, 1'b0, 18'h2F00B};
        tbl[3] = '{1'b1, 18'h3FFFF, 1'b1, 1'b1, 18'h3FFFF};
        tbl[4] = '{1'b1, 18'h00001, 1'b1, 1'b1, 18'h00001};
        tbl[5] = '{1'b0, 18'h22222, 1'b1, 1'b0, 18'h00001};

        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; complete_div = 1'b0;
        mean_in = '0; acc_count = 8'd0; m_ready = 1'b1;
        model_reset();
        prev_mv_act = 0; prev_to_act = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // per-cycle handshake table, first edge after reset has s_ready low
        for (int i = 0; i < 6; i++) begin
            s_valid = tbl[i].sv;
            s_data  = tbl[i].sd;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_s_ready", i),   32'(s_ready),   32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_acc_start", i), 32'(acc_start), 32'(tbl[i].as));
            chk($sformatf("tbl%0d_acc_eeg", i),   32'(acc_eeg),   32'(tbl[i].eeg));
            chk($sformatf("tbl%0d_busy", i),      32'(busy),      32'd0);
            chk($sformatf("tbl%0d_start_div", i), 32'(start_div), 32'd0);
        end
        s_valid = 1'b0;

        // abort the partial window; no pulses may follow without new samples
        pulse_reset();
        repeat (6) step();

        // constant 1.0 stream, back-to-back
        run_window(1, 0, 3, 0, 0, 0);
        chk("t1_acc_pulses", 32'(acc_pulses), 32'(WIN_LEN));
        chk("t1_sd_pulses",  32'(sd_pulses),  32'd1);
        chk("t1_mv_latency", 32'((mv_cyc - sd_cyc) <= 8 && mv_cyc > sd_cyc), 32'd1);
        chk("t1_m_data",     32'(m_data),     32'h01000);

        // random gaps and data
        run_window(0, 1, 3, 0, 0, 0);
        chk("t2_acc_pulses", 32'(acc_pulses), 32'(WIN_LEN));

        // downstream stall of 20 cycles
        run_window(0, 1, 5, 0, 20, 0);
        chk("t3_mv_cycles", 32'(mv_cycles), 32'd21);

        // completion edge on the last allowed cycle still wins
        run_window(0, 0, TIMEOUT, 0, 0, 0);
        chk("edge_at_limit_err", 32'(err_timeout), 32'd0);
        chk("edge_at_limit_mv",  32'(mv_cycles),   32'd1);

        // complete_div stuck high -> timeout
        run_window(0, 1, 3, 1, 0, 0);
        chk("t4_err_timeout", 32'(err_timeout), 32'd1);
        chk("t4_no_m_valid",  32'(mv_cycles),   32'd0);
        chk("t4_to_latency",  32'(to_cyc - sd_cyc), 32'(TIMEOUT + 1));
        chk("t4_idle_busy",   32'(busy),        32'd0);

        // reset while waiting for the divider
        div_lat = 1000; hold_high = 0;
        begin
            int guard = 0;
            while (e_n != 5 && guard < 1000) begin
                s_valid = 1'b1;
                s_data  = DATA_W'($urandom);
                step();
                guard++;
            end
            chk("t5_reach_div_wait", 32'(guard < 1000), 32'd1);
            chk("t5_busy_in_wait",   32'(busy),         32'd1);
        end
        s_valid = 1'b0;
        pulse_reset();
        repeat (4) step();
        run_window(0, 1, 3, 0, 0, 0);
        chk("t5_acc_pulses", 32'(acc_pulses), 32'(WIN_LEN));
        chk("t5_mv_cycles",  32'(mv_cycles),  32'd1);

        // edge one cycle too late -> timeout
        run_window(0, 0, TIMEOUT + 1, 0, 0, 0);
        chk("late_edge_err",     32'(err_timeout),      32'd1);
        chk("late_edge_latency", 32'(to_cyc - sd_cyc),  32'(TIMEOUT + 1));

`ifdef MEAN_WIN_CNT_CHK_EN
        pulse_reset();
        run_window(0, 0, 3, 0, 0, 0);
        chk("t6_match_err_count", 32'(err_count), 32'd0);
        run_window(0, 0, 3, 0, 0, 1);
        chk("t6_force_err_count", 32'(err_count), 32'd1);
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
